// File: rtl/mips_fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, fetches over a req/valid handshake, issues instr/Opcode.
// Optional ILLEGAL_OPCODE_TRAP_EN halts with fetch_err on opcodes outside the supported set.
module mips_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  Opcode,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        zero,
  output logic [31:0] pc,
  output logic        fetch_err
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_ISSUE, S_HALT} state_t;

  state_t      state, state_n;
  logic [31:0] pc_n, instr_n, pc4, next_pc, br_off;
  logic [7:0]  wait_cnt, wait_cnt_n;
  logic        err_n;

`ifdef ILLEGAL_OPCODE_TRAP_EN
  function automatic logic opcode_legal(input logic [5:0] op);
    case (op)
      6'b000000, 6'b001100, 6'b001101, 6'b001001,
      6'b100011, 6'b101011, 6'b000100, 6'b000010: opcode_legal = 1'b1;
      default:                                    opcode_legal = 1'b0;
    endcase
  endfunction
`endif

  assign Opcode    = instr[31:26];
  assign imem_addr = pc;

  // Jump outranks a taken branch; PC arithmetic wraps silently.
  assign pc4     = pc + 32'd4;
  assign br_off  = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign next_pc = Jump            ? {pc4[31:28], instr[25:0], 2'b00} :
                   (Branch && zero) ? pc4 + br_off : pc4;

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    instr_n    = instr;
    err_n      = fetch_err;
    wait_cnt_n = wait_cnt;
    case (state)
      S_REQ: begin
        wait_cnt_n = 8'd0;
        state_n    = S_WAIT;
      end
      S_WAIT: begin
        if (imem_valid) begin
          instr_n    = imem_rdata;
          wait_cnt_n = 8'd0;
`ifdef ILLEGAL_OPCODE_TRAP_EN
          if (!opcode_legal(imem_rdata[31:26])) begin
            err_n   = 1'b1;
            state_n = S_HALT;
          end else begin
            state_n = S_ISSUE;
          end
`else
          state_n = S_ISSUE;
`endif
        end else if (wait_cnt == 8'(MAX_WAIT - 1)) begin
          err_n   = 1'b1;
          state_n = S_HALT;
        end else begin
          wait_cnt_n = wait_cnt + 8'd1;
        end
      end
      S_ISSUE: begin
        if (!stall) begin
          pc_n    = next_pc;
          state_n = S_REQ;
        end
      end
      default: state_n = S_HALT;
    endcase
  end

  // imem_req and instr_valid are registered copies of the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      instr       <= 32'd0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      wait_cnt    <= 8'd0;
      imem_req    <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instr       <= instr_n;
      fetch_err   <= err_n;
      wait_cnt    <= wait_cnt_n;
      imem_req    <= (state_n == S_WAIT);
      instr_valid <= (state_n == S_ISSUE);
    end
  end

endmodule
